// File: rtl/fpga_puf_pkg.sv
// Shared definitions for the PUF challenge fetch path.
//   state_t        : read-master FSM states
//   BEAT_BYTES     : bytes per AXI data beat (512-bit bus)
//   BEAT_SHIFT     : log2(BEAT_BYTES)
//   BOUNDARY_4K    : AXI burst boundary in bytes
//   BOUNDARY_SHIFT : log2(BOUNDARY_4K)
package fpga_puf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned BEAT_BYTES     = 64;
  localparam int unsigned BEAT_SHIFT     = 6;
  localparam int unsigned BOUNDARY_4K    = 4096;
  localparam int unsigned BOUNDARY_SHIFT = 12;

endpackage

// File: rtl/fpga_puf_axis_reg_slice.sv
// One-entry forward register slice between the AXI R channel and the
// AXI-Stream challenge output.
//   aclk, areset_n        : clock, asynchronous active-low reset
//   s_valid/s_ready       : upstream handshake (s_ready = !m_valid || m_ready)
//   s_data/s_last         : upstream payload and end-of-transfer flag
//   m_valid/m_ready       : downstream handshake
//   m_data/m_last         : registered payload, held while stalled
module fpga_puf_axis_reg_slice
  import fpga_puf_pkg::*;
#(
  parameter int DATA_W = 512
) (
  input  logic              aclk,
  input  logic              areset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  logic              vld_p0;
  logic              last_p0;
  logic [DATA_W-1:0] data_p0;
  logic              load;

  // The slot can accept whenever it is empty or being drained this cycle,
  // which sustains one beat per cycle with m_ready held high.
  assign s_ready = !vld_p0 || m_ready;
  assign load    = s_valid && s_ready;

  // ---- stage p0: register slot ----
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else if (load) begin
      vld_p0  <= 1'b1;
      last_p0 <= s_last;
    end else if (m_ready) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (load) begin
      data_p0 <= s_data;
    end
  end

  assign m_valid = vld_p0;
  assign m_last  = last_p0;
  assign m_data  = data_p0;

endmodule

// File: rtl/fpga_puf_axi_read_master.sv
// AXI4 read master that fetches a contiguous block of challenge data and
// streams it, in address order, to the PUF core over AXI-Stream.
//   aclk, areset_n             : clock, asynchronous active-low reset
//   ctrl_start                 : one-cycle start, honoured only when idle
//   ctrl_done                  : one-cycle pulse when the transfer completes
//   ctrl_addr_offset           : 64-byte aligned start byte address
//   ctrl_xfer_size_in_bytes    : byte count (rounded up to whole beats)
//   m_axi_ar*                  : AXI4 read-address channel
//   m_axi_r*                   : AXI4 read-data channel
//   m_axis_t*                  : AXI4-Stream challenge output
module fpga_puf_axi_read_master
  import fpga_puf_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 32,
  parameter int C_MAX_OUTSTANDING  = 16,
  parameter int C_BURST_LEN        = 64
) (
  input  logic                          aclk,
  input  logic                          areset_n,
  input  logic                          ctrl_start,
  output logic                          ctrl_done,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  ctrl_xfer_size_in_bytes,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                          m_axi_rlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tlast
);

  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int XW     = C_XFER_SIZE_WIDTH;
  localparam int BEAT_W = XW - int'(BEAT_SHIFT) + 1;
  localparam int OUT_W  = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int BS     = int'(BOUNDARY_SHIFT);

  // ceil(bytes / 64); a partial last beat is fetched whole.
  function automatic logic [BEAT_W-1:0] beats_of(input logic [XW-1:0] bytes);
    logic [XW:0] sum;
    sum = {1'b0, bytes} + (XW+1)'(BEAT_BYTES - 1);
    return sum[XW:BEAT_SHIFT];
  endfunction

  // min(remaining beats, C_BURST_LEN, beats left before the next 4 KiB line)
  function automatic logic [8:0] burst_len(input logic [BS-1:0]     addr_lo,
                                           input logic [BEAT_W-1:0] rem);
    logic [BS:0]       room_bytes;
    logic [BEAT_W-1:0] room;
    logic [BEAT_W-1:0] len;
    room_bytes = (BS+1)'(BOUNDARY_4K) - {1'b0, addr_lo};
    room       = BEAT_W'(room_bytes >> BEAT_SHIFT);
    len        = rem;
    if (len > BEAT_W'(C_BURST_LEN)) len = BEAT_W'(C_BURST_LEN);
    if (len > room)                 len = room;
    return len[8:0];
  endfunction

  state_t            state;
  logic [AW-1:0]     next_addr;
  logic [BEAT_W-1:0] ar_rem;
  logic [BEAT_W-1:0] r_total;
  logic [BEAT_W-1:0] r_cnt;
  logic [8:0]        blen;
  logic [OUT_W-1:0]  outstanding;

  logic [8:0]        cur_len;
  logic [BEAT_W-1:0] size_beats;
  logic              ar_hs;
  logic              r_hs;
  logic              r_last_hs;
  logic              t_last_hs;
  logic              can_issue;
  logic              slice_last;

  assign size_beats = beats_of(ctrl_xfer_size_in_bytes);
  assign cur_len    = burst_len(next_addr[BS-1:0], ar_rem);
  assign ar_hs      = m_axi_arvalid && m_axi_arready;
  assign r_hs       = m_axi_rvalid && m_axi_rready;
  assign r_last_hs  = r_hs && m_axi_rlast;
  assign t_last_hs  = m_axis_tvalid && m_axis_tready && m_axis_tlast;
  assign can_issue  = outstanding < OUT_W'(C_MAX_OUTSTANDING);

  // End of transfer comes from our own beat count; AXI rlast only closes
  // individual bursts.
  assign slice_last = (r_cnt == r_total - BEAT_W'(1));

  // Control FSM and AR channel. arvalid drops for one cycle after each
  // handshake so the next burst is sized from the updated address/remainder
  // and the outstanding limit seen by the next request is already current.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state         <= IDLE;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      next_addr     <= '0;
      ar_rem        <= '0;
      r_total       <= '0;
      blen          <= '0;
      ctrl_done     <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctrl_start) begin
            next_addr <= ctrl_addr_offset;
            ar_rem    <= size_beats;
            r_total   <= size_beats;
            if (size_beats == '0) begin
              state     <= DONE;
              ctrl_done <= 1'b1;
            end else begin
              state <= ADDR;
            end
          end
        end
        ADDR: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            next_addr     <= next_addr + (AW'(blen) << BEAT_SHIFT);
            ar_rem        <= ar_rem - BEAT_W'(blen);
            if (ar_rem == BEAT_W'(blen)) begin
              state <= DRAIN;
            end
          end else if (!m_axi_arvalid && can_issue) begin
            m_axi_arvalid <= 1'b1;
            m_axi_araddr  <= next_addr;
            m_axi_arlen   <= 8'(cur_len - 9'd1);
            blen          <= cur_len;
          end
        end
        DRAIN: begin
          if (t_last_hs) begin
            state     <= DONE;
            ctrl_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Beats received so far in this transfer.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_cnt <= '0;
    end else if (state == IDLE && ctrl_start) begin
      r_cnt <= '0;
    end else if (r_hs) begin
      r_cnt <= r_cnt + BEAT_W'(1);
    end
  end

  // In-flight bursts: AR handshake opens one, rlast handshake closes one.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      outstanding <= '0;
    end else begin
      unique case ({ar_hs, r_last_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  fpga_puf_axis_reg_slice #(
    .DATA_W (DW)
  ) u_slice (
    .aclk     (aclk),
    .areset_n (areset_n),
    .s_valid  (m_axi_rvalid),
    .s_ready  (m_axi_rready),
    .s_data   (m_axi_rdata),
    .s_last   (slice_last),
    .m_valid  (m_axis_tvalid),
    .m_ready  (m_axis_tready),
    .m_data   (m_axis_tdata),
    .m_last   (m_axis_tlast)
  );

endmodule

// File: tb/tb_fpga_puf_axi_read_master.sv
module tb_fpga_puf_axi_read_master;

  localparam int AW   = 64;
  localparam int DW   = 512;
  localparam int XW   = 32;
  localparam int MAXO = 16;
  localparam int BL   = 64;

  logic          aclk;
  logic          areset_n;
  logic          ctrl_start;
  logic          ctrl_done;
  logic [AW-1:0] ctrl_addr_offset;
  logic [XW-1:0] ctrl_xfer_size_in_bytes;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic          m_axi_rlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;

  fpga_puf_axi_read_master dut (
    .aclk                    (aclk),
    .areset_n                (areset_n),
    .ctrl_start              (ctrl_start),
    .ctrl_done               (ctrl_done),
    .ctrl_addr_offset        (ctrl_addr_offset),
    .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
    .m_axi_arvalid           (m_axi_arvalid),
    .m_axi_arready           (m_axi_arready),
    .m_axi_araddr            (m_axi_araddr),
    .m_axi_arlen             (m_axi_arlen),
    .m_axi_rvalid            (m_axi_rvalid),
    .m_axi_rready            (m_axi_rready),
    .m_axi_rdata             (m_axi_rdata),
    .m_axi_rlast             (m_axi_rlast),
    .m_axis_tvalid           (m_axis_tvalid),
    .m_axis_tready           (m_axis_tready),
    .m_axis_tdata            (m_axis_tdata),
    .m_axis_tlast            (m_axis_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [63:0] addr;
    int          len;
  } burst_t;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model of the current transfer
  burst_t      exp_ar[$];
  logic [63:0] xfer_off;
  int          xfer_beats;
  int          t_idx;
  logic [63:0] salt;

  // memory-side slave model
  burst_t slv_q[$];
  int     slv_beat = 0;
  int     out_cnt  = 0;
  int     max_out  = 0;
  int     n_ar     = 0;

  // stimulus knobs (percent probabilities)
  int ar_prob = 100;
  int r_prob  = 100;
  int t_mode  = 0;
  int t_prob  = 100;
  int r_hold  = 0;

  int cyc = 0;
  int done_cnt, last_done_cyc, tlast_cyc, first_t, last_t;

  logic          p_ar_stall = 1'b0;
  logic [AW-1:0] p_araddr;
  logic [7:0]    p_arlen;
  logic          p_t_stall = 1'b0;
  logic [DW-1:0] p_tdata;
  logic          p_tlast;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    return {8{a ^ salt}};
  endfunction

  task automatic set_knobs(input int ar, input int r, input int tm, input int tp, input int hold);
    ar_prob = ar; r_prob = r; t_mode = tm; t_prob = tp; r_hold = hold;
  endtask

  // Expected AR bursts and beats from the addressing rules alone.
  task automatic plan(input logic [63:0] off, input longint size);
    longint rem, room, len;
    logic [63:0] a;
    exp_ar.delete();
    xfer_off   = off;
    xfer_beats = int'((size + 63) / 64);
    rem        = xfer_beats;
    a          = off;
    while (rem > 0) begin
      room = (4096 - longint'(a % 4096)) / 64;
      len  = rem;
      if (len > BL)   len = BL;
      if (len > room) len = room;
      exp_ar.push_back('{a, int'(len)});
      a   = a + 64'(len * 64);
      rem = rem - len;
    end
    t_idx = 0; done_cnt = 0; first_t = -1; last_t = -1;
    tlast_cyc = -1; last_done_cyc = -1; max_out = 0; n_ar = 0;
    salt = {$urandom(), $urandom()};
  endtask

  // One clock: sample handshakes just before the edge, then drive inputs.
  task automatic step();
    logic   ar_hs, r_hs, t_hs;
    burst_t b;
    @(posedge aclk);
    cyc++;
    ar_hs = m_axi_arvalid && m_axi_arready;
    r_hs  = m_axi_rvalid && m_axi_rready;
    t_hs  = m_axis_tvalid && m_axis_tready;
    if (p_ar_stall) begin
      check_eq("ar_hold", m_axi_arvalid, 1'b1);
      check_eq("ar_addr_stable", m_axi_araddr, p_araddr);
      check_eq("ar_len_stable", m_axi_arlen, p_arlen);
    end
    p_ar_stall = m_axi_arvalid && !m_axi_arready;
    p_araddr   = m_axi_araddr;
    p_arlen    = m_axi_arlen;
    if (p_t_stall) begin
      check_eq("t_hold", m_axis_tvalid, 1'b1);
      check_eq("t_data_stable", m_axis_tdata, p_tdata);
      check_eq("t_last_stable", m_axis_tlast, p_tlast);
    end
    p_t_stall = m_axis_tvalid && !m_axis_tready;
    p_tdata   = m_axis_tdata;
    p_tlast   = m_axis_tlast;
    if (ar_hs) begin
      check_eq("ar_limit", out_cnt < MAXO, 1'b1);
      if (exp_ar.size() > 0) begin
        b = exp_ar.pop_front();
        check_eq("ar_addr", m_axi_araddr, b.addr);
        check_eq("ar_len", m_axi_arlen, 8'(b.len - 1));
      end else begin
        check_eq("ar_unexpected", m_axi_arvalid, 1'b0);
      end
      slv_q.push_back('{m_axi_araddr, int'(m_axi_arlen) + 1});
      out_cnt++;
      n_ar++;
      if (out_cnt > max_out) max_out = out_cnt;
    end
    if (r_hs && slv_q.size() > 0) begin
      if (m_axi_rlast) begin
        void'(slv_q.pop_front());
        slv_beat = 0;
        out_cnt--;
      end else begin
        slv_beat++;
      end
    end
    if (t_hs) begin
      if (t_idx < xfer_beats) begin
        check_eq("t_data", m_axis_tdata, pat(xfer_off + 64'(t_idx) * 64));
        check_eq("t_last", m_axis_tlast, t_idx == xfer_beats - 1);
      end else begin
        check_eq("t_unexpected", m_axis_tvalid, 1'b0);
      end
      if (m_axis_tlast) tlast_cyc = cyc;
      if (first_t < 0) first_t = cyc;
      last_t = cyc;
      t_idx++;
    end
    if (ctrl_done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
    #1;
    m_axi_arready = ($urandom_range(99) < ar_prob);
    m_axis_tready = (t_mode != 0) ? (cyc % 2 == 0) : ($urandom_range(99) < t_prob);
    if (r_hold > 0) r_hold--;
    if (!(m_axi_rvalid && !r_hs)) begin
      if (slv_q.size() > 0 && r_hold == 0 && $urandom_range(99) < r_prob) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = pat(slv_q[0].addr + 64'(slv_beat) * 64);
        m_axi_rlast  = (slv_beat == slv_q[0].len - 1);
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rdata  = {16{$urandom()}};
      end
    end
  endtask

  task automatic run_xfer(input logic [63:0] off, input int size, input string name, input bit noise);
    int c0, n;
    plan(off, size);
    ctrl_addr_offset        = off;
    ctrl_xfer_size_in_bytes = size;
    ctrl_start              = 1'b1;
    c0 = cyc;
    step();
    ctrl_start = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 30000) begin
      if (noise && $urandom_range(9) == 0) begin
        ctrl_start              = 1'b1;
        ctrl_addr_offset        = {$urandom(), $urandom()} & ~64'h3f;
        ctrl_xfer_size_in_bytes = $urandom_range(4096);
      end
      step();
      ctrl_start = 1'b0;
      n++;
    end
    repeat (4) step();
    check_eq({name, "_done_once"}, done_cnt, 1);
    check_eq({name, "_beats"}, t_idx, xfer_beats);
    check_eq({name, "_ar_left"}, exp_ar.size(), 0);
    if (xfer_beats == 0) check_eq({name, "_done_lat"}, last_done_cyc - c0, 2);
    else                 check_eq({name, "_done_after_tlast"}, last_done_cyc - tlast_cyc, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [63:0] off;
    areset_n = 1'b1;
    ctrl_start = 1'b0;
    ctrl_addr_offset = '0;
    ctrl_xfer_size_in_bytes = '0;
    m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b0;
    m_axi_rdata = '0;
    m_axi_rlast = 1'b0;
    m_axis_tready = 1'b1;
    #2 areset_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_arvalid", m_axi_arvalid, 1'b0);
    check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_tlast", m_axis_tlast, 1'b0);
    check_eq("rst_done", ctrl_done, 1'b0);
    check_eq("rst_rready", m_axi_rready, 1'b1);
    areset_n = 1'b1;

    set_knobs(100, 100, 0, 100, 0);
    run_xfer(64'h2000, 0, "sz0", 0);
    check_eq("sz0_no_ar", n_ar, 0);

    run_xfer(64'h1000, 8192, "t4k", 0);
    check_eq("t4k_bursts", n_ar, 2);
    check_eq("t4k_rate", last_t - first_t, 127);

    run_xfer(64'h0F80, 200, "tsplit", 0);
    check_eq("tsplit_bursts", n_ar, 2);

    set_knobs(100, 100, 1, 0, 0);
    run_xfer(64'h40, 65, "tstall", 0);
    check_eq("tstall_bursts", n_ar, 1);

    set_knobs(100, 100, 0, 100, 100);
    run_xfer(64'h0, 65536, "t64k", 0);
    check_eq("t64k_max_out", max_out, MAXO);
    check_eq("t64k_bursts", n_ar, 16);

    set_knobs(100, 80, 0, 90, 150);
    run_xfer(64'h30000, 131072, "t128k", 1);
    check_eq("t128k_max_out", max_out, MAXO);

    for (int i = 0; i < 6; i++) begin
      set_knobs($urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(1),
                $urandom_range(30, 100), $urandom_range(20));
      off = 64'($urandom_range(16383)) << 6;
      run_xfer(off, $urandom_range(6000), "rnd", 1);
    end

    // abort a transfer in DRAIN with reset
    set_knobs(100, 70, 0, 50, 0);
    plan(64'h0, 8192);
    ctrl_addr_offset        = '0;
    ctrl_xfer_size_in_bytes = 8192;
    ctrl_start              = 1'b1;
    step();
    ctrl_start = 1'b0;
    n = 0;
    while ((exp_ar.size() > 0 || t_idx < 10) && n < 5000) begin
      step();
      n++;
    end
    check_eq("rst_reached_drain", exp_ar.size() == 0 && t_idx >= 10, 1'b1);
    #2 areset_n = 1'b0;
    #1;
    check_eq("abort_arvalid", m_axi_arvalid, 1'b0);
    check_eq("abort_tvalid", m_axis_tvalid, 1'b0);
    check_eq("abort_tlast", m_axis_tlast, 1'b0);
    check_eq("abort_done", ctrl_done, 1'b0);
    check_eq("abort_rready", m_axi_rready, 1'b1);
    slv_q.delete();
    slv_beat = 0;
    out_cnt = 0;
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    p_ar_stall = 1'b0;
    p_t_stall = 1'b0;
    done_cnt = 0;
    repeat (3) step();
    check_eq("abort_no_done", done_cnt, 0);
    areset_n = 1'b1;
    set_knobs(100, 100, 0, 100, 0);
    run_xfer(64'h5000, 1000, "post_rst", 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
